// File: rtl/imem_pkg.sv
// imem_pkg: types and constants shared by the instruction-memory responder.
//   imem_state_t       : responder FSM states (IDLE, LOAD, HOLD, RUN)
//   NOP_INSTR          : word returned whenever a fetch cannot be served
//   DEF_DEPTH          : default number of stored instruction words
//   DEF_HOLD_CYC       : default cycles the core is held in reset after a load
//   even_parity()      : parity bit that makes {word, bit} have an even number of ones
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          DEF_DEPTH    = 256;
  localparam int          DEF_HOLD_CYC = 4;

  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: instruction word storage, one synchronous write port and one
// asynchronous read port. Contents are never reset.
// Optional feature macro: IMEM_PARITY_EN adds one stored even-parity bit per word.
// Ports:
//   CLK    in   clock, writes on posedge
//   we     in   write enable
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address
//   rdata  out  read data (combinational)
//   rpar   out  stored parity bit of the read word (IMEM_PARITY_EN only)
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
`ifdef IMEM_PARITY_EN
  output logic          rpar,
`endif
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];
`ifdef IMEM_PARITY_EN
  logic        par_r [DEPTH];
`endif

  // Write port: word (and its parity) captured at write time, no reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[waddr] <= wdata;
`ifdef IMEM_PARITY_EN
      par_r[waddr] <= even_parity(wdata);
`endif
    end
  end

  // Asynchronous read port.
  always_comb begin
    rdata = mem_r[raddr];
`ifdef IMEM_PARITY_EN
    rpar  = par_r[raddr];
`endif
  end

endmodule

// File: rtl/imem_responder.sv
// imem_responder: loadable instruction memory that serves a core's fetches
// and holds the core in reset while a program is being loaded.
// Optional feature macro: IMEM_PARITY_EN enables per-word parity checking.
// Ports:
//   CLK          in   clock
//   RST          in   synchronous active-high reset
//   PC           in   fetch byte address
//   Instr        out  fetched word (NOP when not servable)
//   core_rstn_o  out  active-low core reset, high only in RUN
//   load_start   in   starts a program load (len 1..DEPTH)
//   load_len     in   number of words to load
//   load_valid   in   load word valid
//   load_data    in   load word
//   load_ready   out  ready for a load word (LOAD state)
//   fetch_fault  out  sticky bad-fetch flag
//   busy         out  high whenever not in RUN
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   PC,
  output logic [31:0]   Instr,
  output logic          core_rstn_o,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          fetch_fault,
  output logic          busy
);

  localparam int          CW        = $clog2(HOLD_CYC + 1) + 1;
  localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_W     = (AW + 1)'(1);
  localparam logic [CW-1:0] HOLD_LAST = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

  imem_state_t   state_r, state_s;
  logic [AW:0]   wptr_r, wptr_s;
  logic [AW:0]   len_r, len_s;
  logic [CW-1:0] hcnt_r, hcnt_s;
  logic          fault_r, fault_s;

  logic          start_ok_s;
  logic          hs_s;
  logic          we_s;
  logic          addr_bad_s;
  logic          par_err_s;
  logic [31:0]   rdata_s;
`ifdef IMEM_PARITY_EN
  logic          rpar_s;
`endif

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .CLK   (CLK),
    .we    (we_s),
    .waddr (wptr_r[AW-1:0]),
    .wdata (load_data),
    .raddr (PC[AW+1:2]),
`ifdef IMEM_PARITY_EN
    .rpar  (rpar_s),
`endif
    .rdata (rdata_s)
  );

  // Request qualification and fetch address/parity checks.
  always_comb begin
    start_ok_s = load_start && (load_len != '0) && (load_len <= DEPTH_W)
                 && (state_r != ST_LOAD);
    hs_s       = (state_r == ST_LOAD) && load_valid;
    // A load word arriving in the reset cycle is dropped with the load.
    we_s       = hs_s && !RST;
    addr_bad_s = (PC[31:AW+2] != '0) || (PC[1:0] != 2'b00);
`ifdef IMEM_PARITY_EN
    par_err_s  = (even_parity(rdata_s) != rpar_s);
`else
    par_err_s  = 1'b0;
`endif
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      wptr_r  <= '0;
      len_r   <= '0;
      hcnt_r  <= '0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      wptr_r  <= wptr_s;
      len_r   <= len_s;
      hcnt_r  <= hcnt_s;
      fault_r <= fault_s;
    end
  end

  // Next-state logic and outputs.
  always_comb begin
    state_s = state_r;
    wptr_s  = wptr_r;
    len_s   = len_r;
    hcnt_s  = hcnt_r;
    fault_s = fault_r;

    case (state_r)
      ST_LOAD: begin
        if (hs_s) begin
          wptr_s = wptr_r + ONE_W;
          if ((wptr_r + ONE_W) == len_r) begin
            state_s = ST_HOLD;
            hcnt_s  = '0;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          wptr_s = wptr_r;
        end
      end
      ST_IDLE, ST_HOLD, ST_RUN: begin
        if (start_ok_s) begin
          // Any accepted start restarts the load and clears the sticky fault.
          state_s = ST_LOAD;
          wptr_s  = '0;
          len_s   = load_len;
          fault_s = 1'b0;
        end else if (state_r == ST_HOLD) begin
          if (hcnt_r >= HOLD_LAST) begin
            state_s = ST_RUN;
          end else begin
            hcnt_s = hcnt_r + CW'(1);
          end
        end else if (state_r == ST_RUN) begin
          if (addr_bad_s || par_err_s) begin
            fault_s = 1'b1;
          end else begin
            fault_s = fault_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs: the core reset drops in the same cycle a restart is accepted.
    core_rstn_o = !RST && (state_r == ST_RUN) && !start_ok_s;
    load_ready  = !RST && (state_r == ST_LOAD);
    busy        = (state_r != ST_RUN);
    fetch_fault = fault_r;
    if (!RST && (state_r == ST_RUN) && !addr_bad_s && !par_err_s) begin
      Instr = rdata_s;
    end else begin
      Instr = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: self-checking bench for imem_responder (default DEPTH=256,
// HOLD_CYC=4). A word-array model plus a "core running" flag predicts Instr.
module tb_imem_responder;

  localparam int DEPTH = 256;
  localparam int HOLD  = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        core_rstn_o;
  logic        load_start;
  logic [8:0]  load_len;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        fetch_fault;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [DEPTH];
  bit          written   [DEPTH];
  bit          running = 1'b0;
  logic [31:0] pend_q [$];

  imem_responder dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC          (PC),
    .Instr       (Instr),
    .core_rstn_o (core_rstn_o),
    .load_start  (load_start),
    .load_len    (load_len),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .fetch_fault (fetch_fault),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    if (!running || pc >= 32'(4 * DEPTH) || pc[1:0] != 2'b00) return 32'h0;
    return model_mem[pc >> 2];
  endfunction

  // Full load of pend_q[0..len-1]; toggle makes load_valid go 1,0,1,0...
  task automatic run_load(input int len, input bit toggle);
    int got = 0;
    int rdy = 0;
    int guard = 0;
    load_start = 1'b1; load_len = 9'(len);
    running = 1'b0;
    tick();
    load_start = 1'b0; load_len = 9'd0;
    while (got < len && guard < 200) begin
      load_valid = toggle ? ((guard % 2) == 0) : 1'b1;
      load_data  = pend_q[got];
      if (load_ready) rdy++;
      if (load_valid && load_ready) begin
        model_mem[got] = load_data;
        written[got]   = 1'b1;
        got++;
      end
      tick();
      guard++;
    end
    load_valid = 1'b0;
    checks++;
    if (got !== len) begin errors++; $display("FAIL load_words got=%0d want=%0d", got, len); end
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL ready_drop got=%b want=0", load_ready); end
    checks++;
    if (rdy !== (toggle ? 2 * len - 1 : len)) begin
      errors++; $display("FAIL ready_cycles got=%0d want=%0d", rdy, toggle ? 2 * len - 1 : len);
    end
  endtask

  // Waits (bounded) for core release and checks the hold length.
  task automatic wait_run();
    int n = 0;
    while (!core_rstn_o && n < 50) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold got=%b want=1", busy); end
      tick();
      n++;
    end
    checks++;
    if (n !== HOLD) begin errors++; $display("FAIL hold_len got=%0d want=%0d", n, HOLD); end
    running = 1'b1;
  endtask

  task automatic fetch_check(input logic [31:0] pc, input string tag);
    PC = pc;
    #1;
    checks++;
    if (Instr !== exp_instr(pc)) begin
      errors++; $display("FAIL %s pc=%h got=%h want=%h", tag, pc, Instr, exp_instr(pc));
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    checks++;
    if ({core_rstn_o, load_ready, fetch_fault, busy, Instr} !== {4'b0001, 32'h0}) begin
      errors++; $display("FAIL reset got=%b%b%b%b/%h want=0001/0", core_rstn_o, load_ready, fetch_fault, busy, Instr);
    end
    RST = 1'b0;
    tick();
    // Zero length in IDLE must not start a load.
    load_start = 1'b1; load_len = 9'd0;
    tick();
    load_start = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL idle_len0 got=%b want=0", load_ready); end
  endtask

  task automatic test_basic();
    pend_q = '{32'h20080005, 32'h20090003, 32'h01095020};
    run_load(3, 1'b0);
    wait_run();
    fetch_check(32'h4, "basic_pc4");
    checks++;
    if (Instr !== 32'h20090003) begin errors++; $display("FAIL basic_const got=%h want=20090003", Instr); end
    fetch_check(32'h0, "basic_pc0");
    fetch_check(32'h8, "basic_pc8");
  endtask

  task automatic test_toggle();
    pend_q = '{$urandom, $urandom};
    run_load(2, 1'b1);
    wait_run();
    fetch_check(32'h0, "toggle_pc0");
    fetch_check(32'h4, "toggle_pc4");
    // Word 2 from the previous program is kept.
    fetch_check(32'h8, "toggle_keep");
  endtask

  task automatic test_random_fetch();
    pend_q.delete();
    for (int i = 0; i < 16; i++) pend_q.push_back($urandom);
    run_load(16, 1'b0);
    wait_run();
    for (int i = 0; i < 10; i++) begin
      fetch_check(32'($urandom_range(0, 15)) << 2, "rand_fetch");
    end
  endtask

  task automatic test_fault();
    fetch_check(32'h400, "oor_instr");
    tick();
    checks++;
    if (fetch_fault !== 1'b1) begin errors++; $display("FAIL oor_fault got=%b want=1", fetch_fault); end
    fetch_check(32'h0, "after_fault");
    tick();
    checks++;
    if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b want=1", fetch_fault); end
    fetch_check(32'h6, "misalign_instr");
    tick();
    checks++;
    if (fetch_fault !== 1'b1) begin errors++; $display("FAIL misalign_fault got=%b want=1", fetch_fault); end
  endtask

  task automatic test_reload();
    PC = 32'h0;
    pend_q = '{$urandom, $urandom};
    load_start = 1'b1; load_len = 9'd2;
    running = 1'b0;
    tick();
    load_start = 1'b0;
    checks++;
    if ({core_rstn_o, busy, fetch_fault, Instr} !== {3'b010, 32'h0}) begin
      errors++; $display("FAIL reload_entry got=%b%b%b/%h want=010/0", core_rstn_o, busy, fetch_fault, Instr);
    end
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = pend_q[i];
      model_mem[i] = pend_q[i];
      tick();
    end
    load_valid = 1'b0;
    wait_run();
    fetch_check(32'h0, "reload_pc0");
    fetch_check(32'h4, "reload_pc4");
  endtask

  task automatic test_ignore();
    load_start = 1'b1; load_len = 9'd0;
    tick();
    load_len = 9'd257;
    tick();
    load_start = 1'b0;
    checks++;
    if ({core_rstn_o, busy} !== 2'b10) begin errors++; $display("FAIL bad_len got=%b%b want=10", core_rstn_o, busy); end
    // Start during LOAD: a restart would need 3 more words.
    pend_q = '{$urandom, $urandom};
    load_start = 1'b1; load_len = 9'd2;
    running = 1'b0;
    tick();
    load_valid = 1'b1; load_data = pend_q[0]; load_len = 9'd0; load_start = 1'b0;
    tick();
    load_valid = 1'b0; load_start = 1'b1; load_len = 9'd3;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = pend_q[1];
    tick();
    load_valid = 1'b0;
    model_mem[0] = pend_q[0]; model_mem[1] = pend_q[1];
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL load_start_ignored got=%b want=0", load_ready); end
    wait_run();
    fetch_check(32'h4, "ignore_pc4");
  endtask

  task automatic test_rst_mid_load();
    logic [31:0] c, d, e;
    c = $urandom; d = $urandom; e = $urandom;
    load_start = 1'b1; load_len = 9'd4;
    running = 1'b0;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = c; tick();
    load_data = d; tick();
    load_valid = 1'b0;
    model_mem[0] = c; model_mem[1] = d;
    RST = 1'b1;
    tick();
    checks++;
    if ({core_rstn_o, load_ready, busy, Instr} !== {3'b001, 32'h0}) begin
      errors++; $display("FAIL rst_mid_load got=%b%b%b/%h want=001/0", core_rstn_o, load_ready, busy, Instr);
    end
    RST = 1'b0;
    tick();
    pend_q = '{e};
    run_load(1, 1'b0);
    wait_run();
    fetch_check(32'h0, "after_rst_pc0");
    fetch_check(32'h4, "kept_after_rst");
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    dut.u_array.mem_r[2] = dut.u_array.mem_r[2] ^ 32'h0000_0010;
    PC = 32'h8;
    #1;
    checks++;
    if (Instr !== 32'h0) begin errors++; $display("FAIL parity_instr got=%h want=0", Instr); end
    tick();
    checks++;
    if (fetch_fault !== 1'b1) begin errors++; $display("FAIL parity_fault got=%b want=1", fetch_fault); end
  endtask
`endif

  initial begin
    RST = 1'b1; PC = 32'h0; load_start = 1'b0; load_len = 9'd0;
    load_valid = 1'b0; load_data = 32'h0;
    test_reset();
    test_basic();
    test_toggle();
    test_random_fetch();
    test_fault();
    test_reload();
    test_ignore();
    test_rst_mid_load();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning instruction words stored (power of two, 16..1024).
REQ-002 The block SHALL have parameter HOLD_CYC, default 4, meaning cycles core_rstn_o stays low after a load completes.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state changes on posedge CLK.
REQ-004 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port PC, input, 32, the fetch byte address from the core.
REQ-006 The block SHALL have port Instr, output, 32, the instruction word returned for PC.
REQ-007 The block SHALL have port core_rstn_o, output, 1, the active-low reset driven to the core's RSTn.
REQ-008 The block SHALL have port load_start, input, 1, a pulse that begins a program load.
REQ-009 The block SHALL have port load_len, input, log2(DEPTH)+1, the word count, sampled with load_start.
REQ-010 The block SHALL have ports load_valid (input, 1), load_data (input, 32) and load_ready (output, 1), the load word handshake.
REQ-011 The block SHALL have port fetch_fault, output, 1, a sticky out-of-range or misaligned fetch flag.
REQ-012 The block SHALL have port busy, output, 1, which is high in any state other than RUN.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, HOLD and RUN.
REQ-014 IDLE SHALL go to LOAD on load_start with load_len in 1..DEPTH; load_len 0 or greater than DEPTH SHALL be ignored and the FSM SHALL stay in its state.
REQ-015 In LOAD, load_ready SHALL be 1; each cycle with load_valid && load_ready SHALL write load_data to mem[wptr] and increment wptr, starting at wptr=0.
REQ-016 When the word accepted is number load_len, LOAD SHALL go to HOLD on the next edge; load_ready SHALL drop in that same next cycle.
REQ-017 HOLD SHALL count HOLD_CYC cycles and then go to RUN; core_rstn_o SHALL be 1 only in RUN.
REQ-018 A valid load_start in RUN or HOLD SHALL go to LOAD on the next edge, reset wptr to 0 and drop core_rstn_o in that same cycle.
REQ-019 load_start in LOAD SHALL be ignored.
REQ-020 The fetch read SHALL be combinational: Instr = mem[PC[log2(DEPTH)+1:2]] in RUN with PC in range and PC[1:0]==0.
REQ-021 Instr SHALL be 32'h00000000 (NOP) when not in RUN, when PC >= 4*DEPTH, or when PC[1:0]!=0.
REQ-022 In RUN, an out-of-range or misaligned PC SHALL set fetch_fault on the next edge; fetch_fault SHALL clear only on reset or on entry to LOAD.
REQ-023 Words beyond load_len SHALL keep their previous contents and are not cleared.

Reset
REQ-024 When RST=1, the state SHALL become IDLE, wptr 0, hold counter 0, fetch_fault 0, and core_rstn_o, load_ready and Instr 0.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 RST asserted during LOAD SHALL abandon the load; words already written SHALL remain.

Configuration
REQ-027 With IMEM_PARITY_EN defined, each stored word SHALL carry an even-parity bit computed at write time.
REQ-028 With IMEM_PARITY_EN defined, a parity mismatch on a RUN fetch SHALL force Instr to NOP and set fetch_fault on the next edge.
REQ-029 Without IMEM_PARITY_EN, there SHALL be no parity storage or checking and fetch_fault SHALL reflect address faults only.

Structure
REQ-030 Package imem_pkg SHALL hold the FSM state enum (imem_state_t), NOP_INSTR = 32'h0, and the default DEPTH and HOLD_CYC.
REQ-031 The storage array SHALL be one sub-module, imem_array: one synchronous write port, one asynchronous read port, and the optional parity bit.

Verification
REQ-032 Reset, then load_start with load_len=3 and words 0x20080005, 0x20090003, 0x01095020 back-to-back: load_ready high for 3 cycles, then HOLD, then core_rstn_o=1 exactly 4 cycles later; PC=4 gives Instr=0x20090003.
REQ-033 A load with load_valid toggling 1,0,1,0: only the handshaked words are written, and wptr reaches load_len before HOLD.
REQ-034 In RUN, PC=0x400 (DEPTH=256): Instr=0 and fetch_fault=1 next cycle and remaining 1; PC=0x6: same; a new load clears fetch_fault.
REQ-035 In RUN, load_start with load_len=2: core_rstn_o drops the same cycle, Instr=0 while busy=1, and the new words are served after HOLD.
REQ-036 load_start with load_len=0, and with load_len=257: no state change; RST mid-LOAD returns to IDLE with core_rstn_o=0.
REQ-037 With IMEM_PARITY_EN, force a flipped bit in the stored word at address 0x8, then fetch PC=0x8: Instr=0 and fetch_fault=1.
